// File: rtl/cpu_seq_ctrl_if.sv
// Bus handshake between the instruction sequencer (master) and memory (slave).
// Carries the strobe/ack pair, write enable, address source select and read data.
interface cpu_seq_ctrl_if;
  logic [15:0] instr_i;
  logic        ack_i;
  logic        stb_o;
  logic        we_o;
  logic        adr_sel;

  modport master (
    input  instr_i,
    input  ack_i,
    output stb_o,
    output we_o,
    output adr_sel
  );

  modport slave (
    output instr_i,
    output ack_i,
    input  stb_o,
    input  we_o,
    input  adr_sel
  );
endinterface

// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle sequencer for the 16-bit CPU: fetch/decode/exec/mem/wb stepping,
// bus strobe handshake with a wait-state timeout, and PC/IR/RF update strobes.
module cpu_seq_ctrl #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  cpu_seq_ctrl_if.master bus,
  input  logic        zero,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_mux,
  output logic        rf_we,
  output logic        illegal_o,
  output logic        bus_err_o,
  output logic        busy,
  output logic [2:0]  state_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6
  } state_t;

  localparam logic [3:0] OP_NOP   = 4'b0000;
  localparam logic [3:0] OP_ALU0  = 4'b0001;
  localparam logic [3:0] OP_ALU1  = 4'b0010;
  localparam logic [3:0] OP_ALU2  = 4'b0011;
  localparam logic [3:0] OP_LOAD  = 4'b0100;
  localparam logic [3:0] OP_STORE = 4'b0101;
  localparam logic [3:0] OP_BRZ   = 4'b0110;
  localparam logic [3:0] OP_JMP   = 4'b0111;
  localparam logic [3:0] OP_HALT  = 4'b1111;

  localparam logic [1:0] PC_INC = 2'b00;
  localparam logic [1:0] PC_REL = 2'b01;
  localparam logic [1:0] PC_ABS = 2'b10;

  localparam logic [3:0] TIMEOUT_CNT = 4'(TIMEOUT);

  state_t     state_reg, state_next;
  logic [3:0] opcode_reg, opcode_next;
  logic [3:0] wait_cnt_reg, wait_cnt_next;

  logic stb, we, adr;
  logic timeout;

  // Only the opcode field feeds sequencing; operand fields go to the decode unit.
  logic unused_operand;
  assign unused_operand = ^bus.instr_i[11:0];

  assign timeout = (wait_cnt_reg == TIMEOUT_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      opcode_reg   <= 4'd0;
      wait_cnt_reg <= 4'd0;
    end else begin
      state_reg    <= state_next;
      opcode_reg   <= opcode_next;
      wait_cnt_reg <= wait_cnt_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    opcode_next = opcode_reg;
    stb         = 1'b0;
    we          = 1'b0;
    adr         = 1'b0;
    ir_we       = 1'b0;
    pc_we       = 1'b0;
    pc_mux      = PC_INC;
    rf_we       = 1'b0;
    illegal_o   = 1'b0;
    bus_err_o   = 1'b0;

    case (state_reg)
      IDLE: state_next = FETCH;

      FETCH: begin
        stb = 1'b1;
        if (bus.ack_i) begin
          ir_we       = 1'b1;
          pc_we       = 1'b1;
          pc_mux      = PC_INC;
          opcode_next = bus.instr_i[15:12];
          state_next  = DECODE;
        end else if (timeout) begin
          bus_err_o  = 1'b1;
          state_next = HALT;
        end
      end

      DECODE: begin
        case (opcode_reg)
          OP_NOP:                       state_next = FETCH;
          OP_ALU0, OP_ALU1, OP_ALU2,
          OP_LOAD, OP_STORE,
          OP_BRZ, OP_JMP:               state_next = EXEC;
          OP_HALT:                      state_next = HALT;
          default: begin
            illegal_o  = 1'b1;
            state_next = FETCH;
          end
        endcase
      end

      EXEC: begin
        case (opcode_reg)
          OP_ALU0, OP_ALU1, OP_ALU2: state_next = WB;
          OP_LOAD, OP_STORE:         state_next = MEM;
          OP_BRZ: begin
            if (zero) begin
              pc_we  = 1'b1;
              pc_mux = PC_REL;
            end
            state_next = FETCH;
          end
          OP_JMP: begin
            pc_we      = 1'b1;
            pc_mux     = PC_ABS;
            state_next = FETCH;
          end
          default: state_next = FETCH;
        endcase
      end

      MEM: begin
        stb = 1'b1;
        adr = 1'b1;
        we  = (opcode_reg == OP_STORE);
        if (bus.ack_i) begin
          state_next = (opcode_reg == OP_LOAD) ? WB : FETCH;
        end else if (timeout) begin
          bus_err_o  = 1'b1;
          state_next = HALT;
        end
      end

      WB: begin
        rf_we      = 1'b1;
        state_next = FETCH;
      end

      HALT: state_next = HALT;

      default: state_next = IDLE;
    endcase

    // Every path out of FETCH/MEM passes through a cycle with stb low or an
    // ack, so clearing here doubles as the clear-on-entry.
    if (stb && !bus.ack_i && !timeout) begin
      wait_cnt_next = wait_cnt_reg + 4'd1;
    end else begin
      wait_cnt_next = 4'd0;
    end
  end

  assign bus.stb_o   = stb;
  assign bus.we_o    = we;
  assign bus.adr_sel = adr;

  assign busy    = (state_reg != IDLE) && (state_reg != HALT);
  assign state_o = state_reg;

endmodule

// File: doc/cpu_seq_ctrl.md
# cpu_seq_ctrl

Multi-cycle instruction sequencer for the 16-bit CPU core. It steps each instruction through fetch, decode, execute, memory and write-back, and drives the `stb_o`/`ack_i` bus handshake. It issues the strobes that gate PC, instruction-register and register-file updates. It sits beside the combinational decode unit, which still generates ALU control, register addresses and shift amounts from the IR that this block latches.

## Interface
Parameters:
- `TIMEOUT`, default 15: maximum cycles a bus request may wait for `ack_i` before bus error (1..15, 4-bit counter).

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `instr_i`  in  16  bus read data; opcode is `instr_i[15:12]`.
- `ack_i`  in  1  bus acknowledge for the current strobe.
- `zero`  in  1  ALU zero flag, sampled in EXEC.
- `stb_o`  out  1  bus request strobe.
- `we_o`  out  1  bus write enable (STORE only).
- `adr_sel`  out  1  bus address source: 0 = PC, 1 = ALU result.
- `ir_we`  out  1  instruction register load pulse.
- `pc_we`  out  1  PC update pulse.
- `pc_mux`  out  2  PC source: 00 = PC+1, 01 = PC+offset, 10 = absolute target.
- `rf_we`  out  1  register file write pulse.
- `illegal_o`  out  1  one-cycle pulse on an undefined opcode.
- `bus_err_o`  out  1  one-cycle pulse on a bus timeout.
- `busy`  out  1  high in every state except IDLE and HALT.
- `state_o`  out  3  current state, for debug.

## Operation
- States and encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.
- Reset:
  - State goes to IDLE immediately on `rst_n` low, including mid-operation.
  - The internal opcode register and timeout counter clear to 0.
  - All outputs are 0 during reset and while in IDLE.
- IDLE: goes to FETCH on the next clock unconditionally.
- FETCH:
  - Drives `stb_o`=1, `we_o`=0, `adr_sel`=0.
  - On `ack_i`, in the same cycle: `ir_we`=1, `pc_we`=1, `pc_mux`=00. The opcode is captured internally from `instr_i[15:12]`. State goes to DECODE.
- DECODE: single cycle; the next state depends on the opcode.
  - 0000 NOP: go to FETCH.
  - 0001–0011 ALU: go to EXEC.
  - 0100 LOAD, 0101 STORE: go to EXEC.
  - 0110 BRZ, 0111 JMP: go to EXEC.
  - 1111 HALT: go to HALT.
  - Any other opcode: `illegal_o`=1 for this cycle, then go to FETCH (executes as NOP).
- EXEC:
  - ALU: go to WB.
  - LOAD or STORE: go to MEM.
  - BRZ: if `zero`=1, `pc_we`=1 with `pc_mux`=01. Then go to FETCH either way.
  - JMP: `pc_we`=1 with `pc_mux`=10, then go to FETCH.
- MEM:
  - Drives `stb_o`=1, `adr_sel`=1, and `we_o`=1 for STORE only.
  - On `ack_i`: LOAD goes to WB; STORE goes to FETCH.
- WB: `rf_we`=1 for one cycle, then go to FETCH.
- HALT: all outputs 0, `busy`=0. Stays in HALT until reset.
- Bus timeout:
  - The wait counter clears on entry to FETCH or MEM and increments each cycle `stb_o` is high without `ack_i`.
  - When the counter equals `TIMEOUT` with no ack: `bus_err_o`=1 for that cycle, then go to HALT. `stb_o` drops the next cycle.
  - If `ack_i` arrives in the same cycle the counter reaches `TIMEOUT`, the ack wins and no error is raised.
- Output behaviour:
  - `ir_we`, `pc_we`, `rf_we`, `illegal_o` and `bus_err_o` are single-cycle pulses, never held.
  - `ack_i` is ignored outside FETCH and MEM.

## Timing
- All state and counter updates happen on the rising edge of `clk`. Outputs are combinational from the state, the opcode register, `ack_i` and `zero`.
- Cycles per instruction, with zero-wait ack:
  - NOP: 2.
  - BRZ, JMP: 3.
  - ALU: 4.
  - STORE: 4.
  - LOAD: 5.
- Each bus wait state adds 1 cycle to FETCH or MEM.
- First `stb_o` appears 1 cycle after `rst_n` deasserts (after the IDLE cycle).
- `stb_o` is held continuously from the first cycle of FETCH or MEM until the ack cycle, inclusive, and drops in the following cycle.

## Test plan
- Reset release, ack tied high, `instr_i`=0x1F0F (ALU) -> `state_o` sequence 0,1,2,3,5,1. `ir_we` and `pc_we` pulse in cycle 1, `rf_we` pulses in cycle 4.
- LOAD 0x4F0F with ack delayed 3 cycles in MEM -> `stb_o`=1, `adr_sel`=1, `we_o`=0 for 4 cycles. WB follows, then `rf_we` pulses once.
- BRZ 0x6000 with `zero`=1 then `zero`=0 -> `pc_we` with `pc_mux`=01 in EXEC only for `zero`=1. Both take 3 cycles.
- Opcode 0x9000 -> `illegal_o` pulses once in DECODE and the next state is FETCH. Opcode 0xF000 -> HALT, `busy`=0, no further `stb_o`.
- No ack with `TIMEOUT`=15 -> `bus_err_o` pulses on the 16th `stb_o` cycle, then HALT. Ack on exactly that cycle -> no error, normal DECODE.
- `rst_n` pulsed low during MEM of a STORE -> `stb_o` and `we_o` drop immediately and `state_o`=0. Fetch restarts 1 cycle after release.
